vectrans2_dot_acc: RTL and testbench
====================================

# vectrans2_dot_acc

Dot-product sequencer and accumulator for the vecTrans2 datapath. It accepts a stream of signed operand pairs and drives them into the adjacent 32x32->32 signed multiplier. The multiplier has a ce-gated output register and is instantiated beside this block. The block consumes the products, sums a vector of programmable length modulo 2^32, and returns the sum through a valid/ready result port.

## Interface
Parameters:
- DATA_WIDTH, 32, operand, product and accumulator width.
- LEN_WIDTH, 16, width of the vector-length field.
- MUL_LATENCY, 1, clock edges from the multiplier sampling din0/din1 with ce=1 to the product appearing on its dout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle request to begin a vector; honoured only in IDLE.
- len  in  LEN_WIDTH  element count, sampled when start is honoured.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair present.
- in_ready  out  1  operand pair accepted on a clock edge where in_valid & in_ready.
- in_a, in_b  in  DATA_WIDTH  signed operands.
- mul_ce  out  1  clock enable to the multiplier.
- mul_din0, mul_din1  out  DATA_WIDTH  multiplier operands.
- mul_dout  in  DATA_WIDTH  multiplier product, low DATA_WIDTH bits.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  DATA_WIDTH  accumulated sum.

## Operation
The block has four states.

- **IDLE**
  - busy=0, in_ready=0, mul_ce=0, res_valid=0.
  - start with len>0: load the remaining counter from len, clear acc, go to RUN.
  - start with len=0: clear acc, go to DONE.
- **RUN**
  - in_ready = (remaining != 0).
  - Each handshake decrements remaining and shifts a 1 into the valid pipe v[MUL_LATENCY-1:0]. A cycle without a handshake shifts in 0.
  - mul_ce=1 every RUN/DRAIN cycle, so the multiplier advances continuously and bubbles are tagged invalid.
  - When the last pair is accepted, go to DRAIN.
- **DRAIN**
  - in_ready=0, mul_ce=1, 0 shifted into v.
  - When the pipe empties, go to DONE, on the same edge as the last accumulate.
- **DONE**
  - res_valid=1, mul_ce=0.
  - On res_valid & res_ready, go to IDLE.

Datapath and boundary rules:
- mul_din0 = in_a and mul_din1 = in_b, combinational pass-through. These ports have no reset value; only handshake cycles are tagged valid.
- Accumulate: on every edge where v[MUL_LATENCY-1]=1, acc <= acc + mul_dout. Two's-complement add, wrap modulo 2^DATA_WIDTH, no saturation, no overflow flag.
- res_data = acc, registered, held stable while res_valid=1.
- start outside IDLE is ignored, and len is not resampled.
- mul_dout is ignored whenever the tap bit is 0, including garbage left in the multiplier register after reset.
- Reset:
  - Asynchronous assertion at any time forces IDLE, remaining=0, v=0 and acc=0.
  - busy, in_ready, mul_ce, res_valid and res_data all go to 0 immediately, independent of clk.
  - An in-flight vector is discarded.

## Timing
- First pair accepted at edge k: the multiplier samples it at edge k and the product is accumulated at edge k+MUL_LATENCY.
- Last pair accepted at edge k: the final accumulate and the DRAIN->DONE transition happen at edge k+MUL_LATENCY, so res_valid is high from then on.
- Throughput is one pair per cycle with in_valid held high. A vector of N back-to-back pairs occupies 1 + N + MUL_LATENCY edges from the start edge to res_valid.
- len=0: res_valid is high from the edge after start, with res_data=0.
- Back-pressure only at the result port. While in DONE, in_ready=0 and mul_ce=0.
- Next start is accepted at the earliest on the edge after the result handshake.

## Test plan
- **Basic back-to-back:** len=4, a={1,2,3,4}, b={5,6,7,8} with in_valid held high.
  - res_data=70 (0x46).
  - res_valid rises exactly MUL_LATENCY edges after the 4th accept.
  - busy high throughout.
- **Signed and wrap:** len=2, a={-3, 0x7FFFFFFF}, b={5, 2}.
  - Products are -15 and 0xFFFFFFFE.
  - res_data=0xFFFFFFEF (-17).
- **Bubbles:** same data as the basic scenario, with in_valid low for 1 or 3 idle cycles between pairs.
  - res_data=70; the accumulator never changes on bubble cycles.
- **Zero length:** start with len=0.
  - res_valid=1 and res_data=0 one edge later.
  - mul_ce stays 0 throughout.
- **Result back-pressure:** hold res_ready=0 for 5 cycles with res_valid high, and pulse start with len=3 during DONE.
  - res_data stays stable and the start is ignored.
  - After res_ready=1 the block returns to IDLE and busy=0.
- **Reset mid-run:** assert reset low after 2 of 4 pairs.
  - All outputs go to 0 immediately.
  - After release, start len=2 with a={2,3}, b={4,5}: res_data=23, with no contamination from the aborted vector.

Source files
------------

// File: rtl/vectrans2_dot_acc.sv
// Dot-product sequencer/accumulator: streams operand pairs into an external
// multiplier, sums tagged products modulo 2^DATA_WIDTH, returns the sum via valid/ready.
module vectrans2_dot_acc #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  mul_ce,
  output logic [DATA_WIDTH-1:0] mul_din0,
  output logic [DATA_WIDTH-1:0] mul_din1,
  input  logic [DATA_WIDTH-1:0] mul_dout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [MUL_LATENCY-1:0] r_v;
  logic [DATA_WIDTH-1:0]  r_acc;
  logic                   r_busy;
  logic                   r_in_ready;
  logic                   r_mul_ce;
  logic                   r_res_valid;

  logic                   w_fire;
  logic                   w_last;
  logic                   w_tap;
  logic [MUL_LATENCY-1:0] w_v_shift;

  assign w_fire    = in_valid & r_in_ready;
  assign w_last    = w_fire && (r_remaining == LEN_WIDTH'(1));
  assign w_tap     = r_v[MUL_LATENCY-1];
  assign w_v_shift = r_v << 1;

  // Operands go straight to the multiplier; only handshake cycles get a valid tag.
  assign mul_din0  = in_a;
  assign mul_din1  = in_b;

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign mul_ce    = r_mul_ce;
  assign res_valid = r_res_valid;
  assign res_data  = r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_v         <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mul_ce    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      // Tap bit marks a product that belongs to the current vector.
      if (w_tap) begin
        r_acc <= r_acc + mul_dout;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_remaining <= len;
              r_in_ready  <= 1'b1;
              r_mul_ce    <= 1'b1;
              r_state     <= S_RUN;
            end else begin
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_v <= w_v_shift | MUL_LATENCY'(w_fire);
          if (w_fire) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
          end
          if (w_last) begin
            r_in_ready <= 1'b0;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_v <= w_v_shift;
          // Leave on the edge that consumes the final tagged product.
          if (w_v_shift == '0) begin
            r_mul_ce    <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vectrans2_dot_acc.sv
// Bench for vectrans2_dot_acc: behavioural multiplier beside the DUT, directed
// and random vectors checked against an arithmetic dot-product model.
module tb_vectrans2_dot_acc;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned ML = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b;
  logic          mul_ce;
  logic [DW-1:0] mul_din0, mul_din1, mul_dout;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  logic [DW-1:0] va [16];
  logic [DW-1:0] vb [16];
  int            vg [16];
  int            acc_edge [16];
  logic [DW-1:0] mpipe [ML];
  logic [DW-1:0] result;

  vectrans2_dot_acc #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MUL_LATENCY(ML)) dut (
    .clk(clk), .reset(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Adjacent multiplier: ce-gated output register, not reset, powers up with garbage.
  initial for (int i = 0; i < int'(ML); i++) mpipe[i] = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= mul_din0 * mul_din1;
      for (int i = 1; i < int'(ML); i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[ML-1];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Running sum as seen ML edges after each accepted pair.
  function automatic logic [DW-1:0] acc_model(input int upto, input int e);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < upto; i++)
      if (acc_edge[i] + int'(ML) <= e) s += va[i] * vb[i];
    return s;
  endfunction

  task automatic run_vector(input int n, input string tag, input int hold,
                            output logic [DW-1:0] res);
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] held;
    int idx, cnt, gap_left, s_edge, gaps, exp_span;
    bit fire;
    exp_sum = '0;
    gaps = 0;
    for (int i = 0; i < n; i++) begin
      exp_sum += va[i] * vb[i];
      gaps += vg[i];
    end
    start = 1'b1;
    len = LW'(n);
    @(negedge clk);
    start = 1'b0;
    len = LW'($urandom);
    s_edge = edge_no;
    check({tag, " busy_after_start"}, DW'(busy), DW'(1));
    if (n == 0) check({tag, " zero_len_ce"}, DW'(mul_ce), DW'(0));
    idx = 0;
    cnt = 0;
    gap_left = (n > 0) ? vg[0] : 0;
    while (idx < n && cnt < 200) begin
      if (gap_left > 0) begin
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; gap_left--;
      end else begin
        in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx];
      end
      #1;
      check({tag, " din0_pass"}, mul_din0, in_a);
      check({tag, " in_ready_run"}, DW'(in_ready), DW'(1));
      check({tag, " ce_run"}, DW'(mul_ce), DW'(1));
      fire = in_valid && in_ready;
      @(negedge clk);
      cnt++;
      if (fire) begin
        acc_edge[idx] = edge_no;
        idx++;
        if (idx < n) gap_left = vg[idx];
      end
      check({tag, " acc_progress"}, res_data, acc_model(idx, edge_no));
    end
    in_valid = 1'b0;
    check({tag, " all_accepted"}, DW'(idx), DW'(n));
    cnt = 0;
    while (!res_valid && cnt < 20) begin
      check({tag, " ce_drain"}, DW'(mul_ce), DW'(1));
      check({tag, " in_ready_drain"}, DW'(in_ready), DW'(0));
      @(negedge clk);
      cnt++;
    end
    if (n > 0) check({tag, " last_to_valid"}, DW'(cnt), DW'(ML));
    exp_span = (n == 0) ? 0 : n + gaps + int'(ML);
    check({tag, " start_to_valid"}, DW'(edge_no - s_edge), DW'(exp_span));
    check({tag, " res_valid"}, DW'(res_valid), DW'(1));
    check({tag, " res_data"}, res_data, exp_sum);
    check({tag, " ce_done"}, DW'(mul_ce), DW'(0));
    check({tag, " in_ready_done"}, DW'(in_ready), DW'(0));
    check({tag, " busy_done"}, DW'(busy), DW'(1));
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin start = 1'b1; len = LW'(3); end
      @(negedge clk);
      start = 1'b0;
      check({tag, " hold_data"}, res_data, held);
      check({tag, " hold_valid"}, DW'(res_valid), DW'(1));
      check({tag, " hold_ce"}, DW'(mul_ce), DW'(0));
    end
    res = res_data;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " busy_idle"}, DW'(busy), DW'(0));
    check({tag, " res_valid_idle"}, DW'(res_valid), DW'(0));
    if (hold > 0) begin
      @(negedge clk);
      check({tag, " start_in_done_ignored"}, DW'(busy), DW'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", DW'(busy), DW'(0));
    check("reset in_ready", DW'(in_ready), DW'(0));
    check("reset mul_ce", DW'(mul_ce), DW'(0));
    check("reset res_valid", DW'(res_valid), DW'(0));
    check("reset res_data", res_data, DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic back-to-back
    for (int i = 0; i < 4; i++) begin
      va[i] = DW'(i + 1); vb[i] = DW'(i + 5); vg[i] = 0;
    end
    run_vector(4, "basic", 0, result);
    check("basic const", result, DW'(70));

    // Signed operands and wrap
    va[0] = -32'sd3;        vb[0] = 32'd5;  vg[0] = 0;
    va[1] = 32'h7FFF_FFFF;  vb[1] = 32'd2;  vg[1] = 0;
    run_vector(2, "signed", 0, result);
    check("signed const", result, 32'hFFFF_FFEF);

    // Bubbles between pairs
    for (int i = 0; i < 4; i++) begin
      va[i] = DW'(i + 1); vb[i] = DW'(i + 5);
    end
    vg[0] = 0; vg[1] = 1; vg[2] = 3; vg[3] = 1;
    run_vector(4, "bubbles", 0, result);
    check("bubbles const", result, DW'(70));

    // Zero length
    run_vector(0, "zero", 0, result);
    check("zero const", result, DW'(0));

    // Result back-pressure with a start pulse during DONE
    for (int i = 0; i < 3; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vg[i] = 0;
    end
    run_vector(3, "backpressure", 5, result);

    // Reset mid-run after two of four pairs
    for (int i = 0; i < 4; i++) begin
      va[i] = DW'(i + 1); vb[i] = DW'(i + 5);
    end
    start = 1'b1; len = LW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      @(negedge clk);
    end
    in_a = va[2]; in_b = vb[2];
    check("pre_reset acc", res_data, DW'(5));
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", DW'(busy), DW'(0));
    check("midrst in_ready", DW'(in_ready), DW'(0));
    check("midrst mul_ce", DW'(mul_ce), DW'(0));
    check("midrst res_valid", DW'(res_valid), DW'(0));
    check("midrst res_data", res_data, DW'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst idle", DW'(busy), DW'(0));
    va[0] = 32'd2; vb[0] = 32'd4; vg[0] = 0;
    va[1] = 32'd3; vb[1] = 32'd5; vg[1] = 0;
    run_vector(2, "after_reset", 0, result);
    check("after_reset const", result, DW'(23));

    // Random vectors with random bubbles
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        va[i] = $urandom; vb[i] = $urandom; vg[i] = $urandom_range(0, 2);
      end
      run_vector(n, "random", (r % 3 == 0) ? 2 : 0, result);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
